// File: rtl/fanin_merge.sv
// fanin_merge: registered round-robin merge of NUM_IN ready/valid streams
// into one stream. Each output word carries the index of its source input.
// A 2-entry output queue keeps out_ready off the in_ready path.

// Per-input ready gate: an input sees ready only when it holds the grant
// and the queue can take a word.
module fanin_merge_lane (
  input  logic gnt,
  input  logic accept_ok,
  output logic rdy
);
  assign rdy = gnt & accept_ok;
endmodule

module fanin_merge #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 17,
  parameter int SRC_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_IN-1:0]            en,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready
);

  localparam int IW = SRC_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SRC_W-1:0]      src;
  } ent_t;

  logic [NUM_IN-1:0][DATA_WIDTH-1:0] din;
  logic [NUM_IN-1:0]                 cand;
  logic [NUM_IN-1:0]                 gnt;
  logic [SRC_W-1:0]                  gidx;
  logic [SRC_W-1:0]                  ptr;
  logic [SRC_W-1:0]                  ptr_nxt;
  logic [1:0]                        count;
  logic                              accept_ok;
  logic                              push;
  logic                              pop;
  ent_t                              q0;
  ent_t                              q1;
  ent_t                              pe;

  assign din  = in_data;
  assign cand = in_valid & en;

  // Round-robin search from ptr upward, wrapping at NUM_IN (not 2^SRC_W).
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = IW'(ptr) + IW'(k);
      if (idx >= IW'(NUM_IN)) idx = idx - IW'(NUM_IN);
      if (!found && cand[idx[SRC_W-1:0]]) begin
        found                = 1'b1;
        gnt[idx[SRC_W-1:0]]  = 1'b1;
        gidx                 = idx[SRC_W-1:0];
      end
    end
  end

  // rst_n is folded in so in_ready is low for the whole reset, not just
  // because count happens to be zero.
  assign accept_ok = (count != 2'd2) & ~flush & rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      fanin_merge_lane u_lane (
        .gnt      (gnt[gi]),
        .accept_ok(accept_ok),
        .rdy      (in_ready[gi])
      );
    end
  endgenerate

  assign push    = |(in_ready & in_valid);
  assign pop     = out_valid & out_ready & ~flush;
  assign pe      = '{data: din[gidx], src: gidx};
  assign ptr_nxt = (gidx == SRC_W'(NUM_IN - 1)) ? '0 : gidx + SRC_W'(1);

  assign out_valid = (count != 2'd0);
  assign out_data  = q0.data;
  assign out_src   = q0.src;

  // Queue and pointer. q0 is the head; on a pop from a single entry q0 is
  // left alone so the outputs hold their last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0    <= '0;
      q1    <= '0;
      count <= 2'd0;
      ptr   <= '0;
    end else if (flush) begin
      count <= 2'd0;
      ptr   <= '0;
    end else begin
      if (push) ptr <= ptr_nxt;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0 <= pe;
          else               q1 <= pe;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) q0 <= q1;
          count <= count - 2'd1;
        end
        // push implies count < 2 and pop implies count > 0, so count == 1
        2'b11: q0 <= pe;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fanin_merge.md
# fanin_merge

Registered round-robin fan-in merger for ready/valid streams. It is the converging counterpart of the fanout ready-combining logic. Where a fanout joins N consumer readies to stall one producer, this block collects N enabled producer streams into one consumer stream, one word per cycle, and tags each word with its source index. It sits in front of a shared sink (memory write port, crossbar output or reducer input). A 2-entry output queue breaks every combinational path from `out_ready` back to `in_ready`.

## Interface
Parameters:
- `NUM_IN`, default 4: number of input streams, minimum 2.
- `DATA_WIDTH`, default 17: word width. Bit 16 is the stream control flag; the block passes it through untouched.
- `SRC_W`, default `$clog2(NUM_IN)`: width of the source tag.

Ports:
- `clk`, input, 1: clock. One clock domain.
- `rst_n`, input, 1: **asynchronous, active-low** reset.
- `flush`, input, 1: synchronous clear of queue and pointer.
- `en`, input, `NUM_IN`: per-input enable (config, quasi-static). A disabled input is never granted.
- `in_valid`, input, `NUM_IN`: producer valids.
- `in_data`, input, `NUM_IN*DATA_WIDTH`: producer words. Input i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`, output, `NUM_IN`: one-hot or zero. High only for the granted input.
- `out_valid`, output, 1: head of queue is valid.
- `out_data`, output, `DATA_WIDTH`: head word.
- `out_src`, output, `SRC_W`: index of the input the head word came from.
- `out_ready`, input, 1: consumer ready.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid[i] & in_ready[i]`.
  - An output transfer occurs when `out_valid & out_ready`.
- Candidates: `cand = in_valid & en`.
- Round-robin pointer `ptr`, width `SRC_W`, resets to 0.
  - Grant goes to the first candidate found searching from `ptr` upward, wrapping modulo `NUM_IN`.
  - After an accepted transfer from input g, `ptr` becomes `(g+1) mod NUM_IN`. Wrap applies when g = `NUM_IN-1`.
  - With no transfer, `ptr` holds. A grant offered but not taken does not move it.
- `in_ready[g] = grant[g] & (count < 2) & ~flush`. All other bits are 0. `in_ready` never depends on `out_ready`.
- Queue:
  - 2 entries of {data, src}, with `count` in 0..2.
  - Push on an input transfer; pop on an output transfer. Simultaneous push and pop leaves `count` unchanged, with correct FIFO order.
  - `out_valid = (count != 0)`. `out_data` and `out_src` come from the head entry.
- Full (`count==2`): all `in_ready` are 0, even if `out_ready=1` that cycle. There is no bypass.
- Empty: `out_valid=0`. `out_data` and `out_src` hold their last value and must not be sampled.
- `flush`:
  - Next cycle: `count=0` and `ptr=0`. Queued words are discarded.
  - During the flush cycle, `in_ready=0` and no input transfer occurs.
  - `out_valid` still reflects the pre-flush queue during the flush cycle. The consumer ignores any pop in that cycle.
- Changing `en` mid-stream is legal. The change takes effect in the same cycle's arbitration. Words already queued are still delivered.
- `NUM_IN` not a power of 2: `ptr` wraps at `NUM_IN`, never at `2^SRC_W`.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator):
  - `count=0`, `ptr=0`, `out_valid=0`, `out_data=0`, `out_src=0`.
  - `in_ready=0` while `rst_n=0`.
- Latency: an input accepted at edge k is visible on `out_valid`/`out_data` after edge k. This is 1 cycle.
- Throughput: 1 word/cycle sustained while `out_ready=1`. `count` settles at 1.
- After `out_ready` has been low long enough to fill the queue, the first cycle with `out_ready=1` pops one entry. `in_ready` reasserts in the following cycle, so there is a 1-bubble refill.
- Reset asserted mid-transfer: state clears immediately. No word is delivered twice, and none is delivered after reset.
- Registered paths: queue and `ptr`.
- Combinational paths: from `in_valid`/`en`/`count` to `in_ready`. The `out_ready` to `in_ready` path is forbidden.

## Test plan
1. Reset, `NUM_IN=4`, all `en`, inputs 0–3 valid with data 0x100+i, `out_ready=1`.
   - Required: output sequence src 0,1,2,3,0,... with data 0x100,0x101,0x102,0x103.
   - Required: first `out_valid` one cycle after the first accept; one word per cycle thereafter.
2. `en=4'b1010`, all inputs valid.
   - Required: only src 1 and 3 appear, alternating.
   - Required: `in_ready[0]` and `in_ready[2]` stay 0.
3. Backpressure: `out_ready=0` for 5 cycles with all inputs valid.
   - Required: exactly 2 words are accepted (src 0, then 1), then `in_ready=0`.
   - Required: after `out_ready=1`, words drain in order 0,1, then src 2 is accepted one cycle after the first pop.
4. Only input 3 valid, then input 0 valid.
   - Required: grant wraps 3 → 0.
   - Required: `ptr` reads 0 after the input-3 transfer, and reads 1 after the input-0 transfer.
5. Queue holding 2 words; pulse `flush` for one cycle.
   - Required: next cycle `out_valid=0`, `ptr=0`.
   - Required: no flushed word is ever delivered afterwards.
6. Assert `rst_n=0` asynchronously mid-stream, between clock edges.
   - Required: `out_valid`, `out_data`, `out_src` and `in_ready` go to 0 immediately.
   - Required: after release, the sequence restarts at src 0.
